// File: rtl/mask_centroid_if.sv
// rtl/mask_centroid_if.sv - video/mask stream in, sync pass-through and per-frame results out
interface mask_centroid_if #(
    parameter int XW = 11,
    parameter int YW = 10,
    parameter int CW = 20
);
    logic [7:0]    mask;
    logic          de_in;
    logic          hsync_in;
    logic          vsync_in;
    logic          de_out;
    logic          hsync_out;
    logic          vsync_out;
    logic [XW-1:0] x_center;
    logic [YW-1:0] y_center;
    logic [CW-1:0] pix_count;
    logic          found;
    logic          valid;
    logic          busy;
    logic          overrun;
    logic [XW-1:0] bbox_xmin;
    logic [XW-1:0] bbox_xmax;
    logic [YW-1:0] bbox_ymin;
    logic [YW-1:0] bbox_ymax;

    modport master (
        output mask, de_in, hsync_in, vsync_in,
        input  de_out, hsync_out, vsync_out, x_center, y_center, pix_count,
               found, valid, busy, overrun, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax
    );

    modport slave (
        input  mask, de_in, hsync_in, vsync_in,
        output de_out, hsync_out, vsync_out, x_center, y_center, pix_count,
               found, valid, busy, overrun, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax
    );
endinterface

// File: rtl/mask_centroid.sv
// rtl/mask_centroid.sv - per-frame mask pixel count and floor centroid via serial divider
// Optional bounding-box tracking is built when MASK_CENTROID_BBOX_EN is defined.
module mask_centroid #(
    parameter int XW      = 11,
    parameter int YW      = 10,
    parameter int CW      = 20,
    parameter int SW      = 32,
    parameter int MIN_PIX = 1
) (
    input  logic           clk,
    input  logic           rst,
    mask_centroid_if.slave bus
);
    localparam int BW = $clog2(SW);

    typedef enum logic [1:0] {ACCUM, DIV_X, DIV_Y, DONE} state_t;
    state_t state_q, state_d;

    logic          de_q, hsync_q, vsync_q;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [SW-1:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW:0]   add_x, add_y;

    logic          frame_end, line_end, obj, busy, accept, load, from_div, last, ge;
    logic [SW-1:0] quo_q, quo_nx, sy_snap_q, rem_q;
    logic [SW:0]   rem_sh, rem_nx, div_ext;
    logic [CW-1:0] div_q;
    logic [BW-1:0] bit_q;
    logic [XW-1:0] qx_q, x_center_q;
    logic [YW-1:0] y_center_q;
    logic [CW-1:0] pix_count_q;
    logic          found_q, valid_q;
    logic          unused_bits;

    assign frame_end   = bus.vsync_in & ~vsync_q;
    assign line_end    = de_q & ~bus.de_in;
    assign obj         = bus.de_in & bus.mask[7];
    assign unused_bits = ^{bus.mask[6:0], rem_nx[SW]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_q    <= 1'b0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            de_q    <= bus.de_in;
            hsync_q <= bus.hsync_in;
            vsync_q <= bus.vsync_in;
        end
    end

    assign bus.de_out    = de_q;
    assign bus.hsync_out = hsync_q;
    assign bus.vsync_out = vsync_q;

    // Accumulators always restart at a frame end, even when that frame is dropped.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        sum_x_d = sum_x_q;
        sum_y_d = sum_y_q;
        cnt_d   = cnt_q;
        add_x   = {1'b0, sum_x_q} + (SW+1)'(x_q);
        add_y   = {1'b0, sum_y_q} + (SW+1)'(y_q);
        if (bus.de_in)
            x_d = x_q + XW'(1);
        else if (line_end)
            x_d = '0;
        if (frame_end)
            y_d = '0;
        else if (line_end)
            y_d = y_q + YW'(1);
        if (frame_end) begin
            sum_x_d = '0;
            sum_y_d = '0;
            cnt_d   = '0;
        end else if (obj) begin
            sum_x_d = add_x[SW] ? '1 : add_x[SW-1:0];
            sum_y_d = add_y[SW] ? '1 : add_y[SW-1:0];
            cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            sum_x_q <= '0;
            sum_y_q <= '0;
            cnt_q   <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            sum_x_q <= sum_x_d;
            sum_y_q <= sum_y_d;
            cnt_q   <= cnt_d;
        end
    end

    // Restoring divider: dividend shifts out of quo_q while quotient bits shift in.
    assign div_ext = {{(SW+1-CW){1'b0}}, div_q};
    assign rem_sh  = {rem_q, quo_q[SW-1]};
    assign ge      = rem_sh >= div_ext;
    assign rem_nx  = ge ? rem_sh - div_ext : rem_sh;
    assign quo_nx  = {quo_q[SW-2:0], ge};
    assign last    = bit_q == BW'(SW-1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM, DONE: begin
                state_d = ACCUM;
                if (frame_end)
                    state_d = (cnt_q < CW'(MIN_PIX)) ? DONE : DIV_X;
            end
            DIV_X:   if (last) state_d = DIV_Y;
            DIV_Y:   if (last) state_d = DONE;
            default: state_d = ACCUM;
        endcase
    end

    assign busy     = (state_q == DIV_X) || (state_q == DIV_Y);
    assign accept   = frame_end & ~busy;
    assign load     = state_d == DONE;
    assign from_div = state_q == DIV_Y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ACCUM;
            quo_q     <= '0;
            rem_q     <= '0;
            bit_q     <= '0;
            div_q     <= '0;
            sy_snap_q <= '0;
            qx_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                quo_q     <= sum_x_q;
                rem_q     <= '0;
                bit_q     <= '0;
                div_q     <= cnt_q;
                sy_snap_q <= sum_y_q;
            end else if (busy) begin
                if (state_q == DIV_X && last) begin
                    qx_q  <= quo_nx[XW-1:0];
                    quo_q <= sy_snap_q;
                    rem_q <= '0;
                    bit_q <= '0;
                end else begin
                    quo_q <= quo_nx;
                    rem_q <= rem_nx[SW-1:0];
                    bit_q <= bit_q + BW'(1);
                end
            end
        end
    end

    // Results are registered on entry to DONE so valid and data appear together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_center_q  <= '0;
            y_center_q  <= '0;
            pix_count_q <= '0;
            found_q     <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            valid_q <= load;
            if (load) begin
                if (from_div) begin
                    found_q     <= 1'b1;
                    x_center_q  <= qx_q;
                    y_center_q  <= quo_nx[YW-1:0];
                    pix_count_q <= div_q;
                end else begin
                    found_q     <= 1'b0;
                    x_center_q  <= '0;
                    y_center_q  <= '0;
                    pix_count_q <= cnt_q;
                end
            end
        end
    end

    assign bus.x_center  = x_center_q;
    assign bus.y_center  = y_center_q;
    assign bus.pix_count = pix_count_q;
    assign bus.found     = found_q;
    assign bus.valid     = valid_q;
    assign bus.busy      = busy;
    assign bus.overrun   = frame_end & busy;

`ifdef MASK_CENTROID_BBOX_EN
    logic [XW-1:0] xmin_q, xmax_q, sxmin_q, sxmax_q, bxmin_q, bxmax_q;
    logic [YW-1:0] ymin_q, ymax_q, symin_q, symax_q, bymin_q, bymax_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xmin_q  <= '1;
            xmax_q  <= '0;
            ymin_q  <= '1;
            ymax_q  <= '0;
            sxmin_q <= '0;
            sxmax_q <= '0;
            symin_q <= '0;
            symax_q <= '0;
            bxmin_q <= '0;
            bxmax_q <= '0;
            bymin_q <= '0;
            bymax_q <= '0;
        end else begin
            if (frame_end) begin
                xmin_q <= '1;
                xmax_q <= '0;
                ymin_q <= '1;
                ymax_q <= '0;
            end else if (obj) begin
                if (x_q < xmin_q) xmin_q <= x_q;
                if (x_q > xmax_q) xmax_q <= x_q;
                if (y_q < ymin_q) ymin_q <= y_q;
                if (y_q > ymax_q) ymax_q <= y_q;
            end
            if (accept) begin
                sxmin_q <= xmin_q;
                sxmax_q <= xmax_q;
                symin_q <= ymin_q;
                symax_q <= ymax_q;
            end
            if (load) begin
                bxmin_q <= from_div ? sxmin_q : '0;
                bxmax_q <= from_div ? sxmax_q : '0;
                bymin_q <= from_div ? symin_q : '0;
                bymax_q <= from_div ? symax_q : '0;
            end
        end
    end

    assign bus.bbox_xmin = bxmin_q;
    assign bus.bbox_xmax = bxmax_q;
    assign bus.bbox_ymin = bymin_q;
    assign bus.bbox_ymax = bymax_q;
`else
    assign bus.bbox_xmin = '0;
    assign bus.bbox_xmax = '0;
    assign bus.bbox_ymin = '0;
    assign bus.bbox_ymax = '0;
`endif
endmodule

// File: doc/mask_centroid.md
# mask_centroid

Consumes the binary skin mask stream produced by the skin-colour binarizer and computes, once per frame, the object pixel count and the integer centroid (x, y) of all mask pixels. It sits directly downstream of the binarizer in the skin-tracking video path. The sync signals pass through with a one-cycle register delay so later stages can stay aligned. Per-frame results are computed during vertical blanking by a serial divider.

## Interface

Parameters:
- XW, 11, x coordinate width (frames up to 2048 wide)
- YW, 10, y coordinate width
- CW, 20, pixel count width
- SW, 32, sum accumulator and dividend width
- MIN_PIX, 1, minimum pixel count for a valid centroid

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- mask  in  8  binarized pixel; bit 7 = 1 marks an object pixel
- de_in  in  1  data enable, active high
- hsync_in  in  1  horizontal sync
- vsync_in  in  1  vertical sync, active high
- de_out / hsync_out / vsync_out  out  1 each  inputs delayed by one clk
- x_center  out  XW  centroid x, floor
- y_center  out  YW  centroid y, floor
- pix_count  out  CW  object pixels in the last frame
- found  out  1  last frame had pix_count >= MIN_PIX
- valid  out  1  one-cycle pulse when the outputs update
- busy  out  1  a division is in progress
- overrun  out  1  one-cycle pulse when a frame end is dropped
- bbox_xmin, bbox_xmax  out  XW each  bounding box x limits (see Configuration)
- bbox_ymin, bbox_ymax  out  YW each  bounding box y limits (see Configuration)

## Operation

- **Pixel coordinates**
  - x counter increments on each cycle with de_in = 1.
  - On the falling edge of de_in, x clears to 0 and y increments.
  - At the frame end, y clears to 0.
- **Accumulation**: on each de_in = 1 cycle with mask[7] = 1:
  - sum_x += x
  - sum_y += y
  - count += 1
  - All three saturate at their all-ones value.
- **Frame end**: the first cycle on which vsync_in = 1 and the registered previous vsync_in = 0.
- **States**
  - ACCUM: accumulates pixels. At frame end, snapshots sum_x, sum_y and count into the divider registers and clears the accumulators. If count < MIN_PIX it goes to DONE; otherwise it goes to DIV_X.
  - DIV_X: restoring shift-subtract division of sum_x by count, one quotient bit per cycle, SW cycles, then DIV_Y.
  - DIV_Y: the same for sum_y, SW cycles, then DONE.
  - DONE: loads x_center, y_center, pix_count and found; pulses valid; returns to ACCUM.
- **Result widths**: quotients are truncated to XW/YW. Because the centroid lies inside the frame, no information is lost.
- **found = 0**: x_center and y_center are loaded with 0, and pix_count is the actual count.
- **Accumulation during division**: accumulation of the next frame continues while busy.
- **Frame end while busy**: the new frame's accumulators are cleared and its data is discarded. The current division completes normally, and overrun pulses on the frame-end cycle.
- **Sync pass-through**: de/hsync/vsync pass through a single register stage, independent of the FSM.

## Timing

- Reset values:
  - All outputs are 0.
  - FSM is in ACCUM.
  - Counters and accumulators are 0.
- A reset asserted mid-division aborts the division. No valid is issued.
- Sync outputs lag their inputs by exactly 1 cycle.
- Let E be the frame-end cycle. Then:
  - valid is high at E + 2·SW + 1 (cycle 65 with the defaults).
  - busy is high from E+1 through E+2·SW.
- If count < MIN_PIX, valid is high at E+1 and busy stays 0.
- Output registers change only in the DONE cycle and otherwise hold their values.

## Configuration

- Macro: MASK_CENTROID_BBOX_EN.
- Defined: the block also tracks min/max of x and y over the object pixels. These are reset to all-ones (min) and 0 (max) at each frame end, and latched to the bbox ports in DONE. With found = 0, all bbox outputs are 0.
- Undefined: the bbox ports exist but are tied to 0, and no tracking logic is built.

## Test plan

- **Single pixel**: 16×8 frame, mask = 255 only at (10,5) -> pix_count = 1, x_center = 10, y_center = 5, found = 1. With the bbox macro, the box is (10,10,5,5).
- **Empty frame**: all mask = 0 -> valid at E+1, found = 0, pix_count = 0, x_center = y_center = 0.
- **Full frame**: 16×8 frame, all mask = 255 -> pix_count = 128, x_center = 7, y_center = 3, valid at E+65.
- **Two pixels**: object pixels at (0,0) and (3,2) -> pix_count = 2, x_center = 1, y_center = 1.
- **Reset mid-division**: rst pulsed at E+20 -> all outputs 0, no valid pulse. The next frame computes correctly.
- **Overrun**: second vsync rising edge at E+10 -> overrun pulse at E+10, the first frame's result still valid at E+65, and the second frame's data discarded.
